uart_debug_history: RTL and testbench
=====================================

Name: uart_debug_history

Overview:
Parametrised successor to the single-frame UART debug latch. Captures every valid received UART frame into a DEPTH-entry ring history. Exposes:
- the newest frame;
- any older entry by index;
- fill level, accepted-frame counter and a sticky overflow flag;
- a match trigger that freezes the history POST_TRIG frames after a chosen frame value.

Sits between the UART receiver and the debug display/readout logic.

Parameters:
FRAME_W, 9, width of a UART frame (data + parity/flag bit)
DEPTH, 8, history entries; power of two, >= 2
IDX_W, $clog2(DEPTH), width of rd_idx
CNT_W, 16, width of frame_count
POST_TRIG, 4, frames still accepted after the matching frame before freezing (0..DEPTH-1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
frame  in  FRAME_W  received frame
frame_valid  in  1  single-cycle strobe, frame valid
freeze  in  1  level; while 1, incoming frames are dropped
clear  in  1  synchronous clear of history state and trigger
match_en  in  1  arms the trigger
match_val  in  FRAME_W  frame value that fires the trigger
rd_idx  in  IDX_W  history index; 0 = newest
last_frame  out  FRAME_W  newest accepted frame
hist_frame  out  FRAME_W  entry at rd_idx, registered
fill_level  out  IDX_W+1  valid entries, 0..DEPTH
frame_count  out  CNT_W  accepted frames, saturating
overflow  out  1  sticky; an entry was overwritten
triggered  out  1  trigger fired and history frozen

Behaviour:
- Reset (rst=1, async):
  - all outputs 0, wr_ptr=0, trigger state IDLE.
  - Memory contents are don't-care because reads are masked by fill_level.
- Accepted frame: frame_valid=1 & freeze=0 & state!=DONE & clear=0. On that edge:
  - mem[wr_ptr]<=frame; wr_ptr<=wr_ptr+1 mod DEPTH; last_frame<=frame.
  - fill_level<=min(fill_level+1, DEPTH).
  - frame_count+=1, saturating at all-ones.
  - If fill_level==DEPTH before the write: overflow<=1.
- Dropped frame (frozen or DONE): no state change anywhere; not counted.
- clear has priority over a simultaneous frame_valid. On clear:
  - wr_ptr, fill_level, frame_count, overflow, last_frame <= 0;
  - trigger state <= IDLE; the frame arriving in the same cycle is discarded.
- hist_frame readout, 1-cycle latency:
  - hist_frame <= mem[(wr_ptr-1-rd_idx) mod DEPTH] if rd_idx < fill_level, else 0.
  - Value is sampled from the pre-edge state. A frame accepted in the same cycle appears from the next read.
- Trigger FSM, states IDLE, ARMED, POST, DONE:
  - IDLE: match_en=1 -> ARMED.
  - ARMED:
    - match_en=0 -> IDLE.
    - Accepted frame == match_val -> POST with post_cnt=0, or straight to DONE if POST_TRIG==0. The matching frame is itself stored.
  - POST: each accepted frame does post_cnt+=1; when post_cnt reaches POST_TRIG -> DONE. match_en is ignored here.
  - DONE: triggered=1, all frames dropped. Leaves only via clear or rst, both -> IDLE. match_en is ignored.
  - freeze=1 in POST stalls post_cnt, since dropped frames do not count.
- Wrap-around: once DEPTH frames are held, each new frame evicts the oldest. rd_idx=DEPTH-1 then addresses the oldest surviving frame.
- Reset mid-operation: immediate async return to the reset values above. No partial write survives.

Test Plan:
- Reset then frames 0x101, 0x0AA, 0x155 -> last_frame=0x155, fill_level=3, frame_count=3, overflow=0. rd_idx=0/1/2 returns 0x155/0x0AA/0x101 one cycle later; rd_idx=3 returns 0.
- Frames 1..10 with DEPTH=8 -> fill_level=8, overflow=1, rd_idx=0 gives 10, rd_idx=7 gives 3, frame_count=10.
- freeze=1 during frames 0x033, 0x044 -> no change to last_frame, fill_level or frame_count. Release freeze, send 0x055 -> last_frame=0x055, count +1.
- match_en=1, match_val=0x1C3, POST_TRIG=4: send 0x010, 0x1C3, then 0x020..0x060 (5 frames).
  - triggered rises on the 4th post frame (0x050); 0x060 is dropped.
  - Results: last_frame=0x050, rd_idx=4 gives 0x1C3, frame_count=6.
- clear asserted in the same cycle as frame_valid with 0x0FF in DONE state -> all counters 0, triggered=0, last_frame=0, 0x0FF not stored. The next frame is accepted normally.
- rst pulsed asynchronously mid-POST -> outputs 0 before the next clock edge, FSM IDLE. With match_en held at 1, the FSM re-arms on the first clock after release.

Source files
------------

// File: rtl/uart_debug_history.sv
// UART frame history: DEPTH-entry ring of accepted frames with indexed readout,
// fill/count/overflow status and a match trigger that freezes capture POST_TRIG frames later.
module uart_debug_history #(
  parameter int FRAME_W   = 9,
  parameter int DEPTH     = 8,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int CNT_W     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame,
  input  logic               frame_valid,
  input  logic               freeze,
  input  logic               clear,
  input  logic               match_en,
  input  logic [FRAME_W-1:0] match_val,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [FRAME_W-1:0] last_frame,
  output logic [FRAME_W-1:0] hist_frame,
  output logic [IDX_W:0]     fill_level,
  output logic [CNT_W-1:0]   frame_count,
  output logic               overflow,
  output logic               triggered
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trig_state_t;

  localparam logic [IDX_W:0]   FULL_C      = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] POST_LAST_C = IDX_W'(POST_TRIG);

  logic [FRAME_W-1:0] mem_r [DEPTH];
  logic [IDX_W-1:0]   wr_ptr_r;
  logic [IDX_W-1:0]   post_cnt_r;
  logic [IDX_W-1:0]   post_cnt_nx_s;
  logic [IDX_W-1:0]   rd_addr_s;
  logic               accept_s;
  logic               match_s;
  logic               in_range_s;
  trig_state_t        state_r;
  trig_state_t        state_nx_s;

  assign accept_s   = frame_valid && !freeze && (state_r != DONE) && !clear;
  assign match_s    = accept_s && (frame == match_val);
  assign rd_addr_s  = wr_ptr_r - IDX_W'(1) - rd_idx;
  assign in_range_s = ({1'b0, rd_idx} < fill_level);

  // Trigger next-state and post-match frame counter
  always_comb begin
    state_nx_s    = state_r;
    post_cnt_nx_s = post_cnt_r;
    if (clear) begin
      state_nx_s    = IDLE;
      post_cnt_nx_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (match_en) begin
            state_nx_s = ARMED;
          end else begin
            state_nx_s = IDLE;
          end
        end
        ARMED: begin
          if (!match_en) begin
            state_nx_s = IDLE;
          end else if (match_s) begin
            post_cnt_nx_s = '0;
            state_nx_s    = (POST_TRIG == 0) ? DONE : POST;
          end else begin
            state_nx_s = ARMED;
          end
        end
        POST: begin
          // Dropped frames (freeze) do not advance the post-match count
          if (accept_s) begin
            post_cnt_nx_s = post_cnt_r + IDX_W'(1);
            if ((post_cnt_r + IDX_W'(1)) == POST_LAST_C) begin
              state_nx_s = DONE;
            end else begin
              state_nx_s = POST;
            end
          end else begin
            state_nx_s = POST;
          end
        end
        DONE:    state_nx_s = DONE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // Trigger state register; triggered is registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      post_cnt_r <= '0;
      triggered  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      post_cnt_r <= post_cnt_nx_s;
      triggered  <= (state_nx_s == DONE);
    end
  end

  // Write pointer, status counters and newest-frame latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      fill_level  <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
      last_frame  <= '0;
    end else if (clear) begin
      wr_ptr_r    <= '0;
      fill_level  <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
      last_frame  <= '0;
    end else if (accept_s) begin
      wr_ptr_r   <= wr_ptr_r + IDX_W'(1);
      last_frame <= frame;
      if (fill_level == FULL_C) begin
        overflow <= 1'b1;
      end else begin
        fill_level <= fill_level + (IDX_W+1)'(1);
      end
      if (frame_count != {CNT_W{1'b1}}) begin
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

  // History storage; contents beyond fill_level are masked on read so need no reset
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= frame;
    end
  end

  // Indexed readout relative to the newest entry, sampled from pre-edge state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_frame <= '0;
    end else if (in_range_s) begin
      hist_frame <= mem_r[rd_addr_s];
    end else begin
      hist_frame <= '0;
    end
  end

endmodule

// File: tb/tb_uart_debug_history.sv
// Directed self-checking bench for uart_debug_history (FRAME_W=9, DEPTH=8, POST_TRIG=4).
module tb_uart_debug_history;

  logic       clk;
  logic       rst;
  logic [8:0] frame;
  logic       frame_valid;
  logic       freeze;
  logic       clear;
  logic       match_en;
  logic [8:0] match_val;
  logic [2:0] rd_idx;
  logic [8:0] last_frame;
  logic [8:0] hist_frame;
  logic [3:0] fill_level;
  logic [15:0] frame_count;
  logic       overflow;
  logic       triggered;

  int checks = 0;
  int errors = 0;

  uart_debug_history #(
    .FRAME_W(9), .DEPTH(8), .IDX_W(3), .CNT_W(16), .POST_TRIG(4)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .freeze(freeze), .clear(clear), .match_en(match_en), .match_val(match_val),
    .rd_idx(rd_idx), .last_frame(last_frame), .hist_frame(hist_frame),
    .fill_level(fill_level), .frame_count(frame_count), .overflow(overflow),
    .triggered(triggered)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic send(input logic [8:0] f);
    @(negedge clk);
    frame = f;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frame = 9'h000; frame_valid = 1'b0; freeze = 1'b0; clear = 1'b0;
    match_en = 1'b0; match_val = 9'h000; rd_idx = 3'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({last_frame, hist_frame, fill_level, frame_count, overflow, triggered} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs got lf=%h hf=%h fill=%0d cnt=%0d ovf=%b trg=%b want all 0",
               last_frame, hist_frame, fill_level, frame_count, overflow, triggered);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [8:0] exp_h [4];
    exp_h[0] = 9'h155; exp_h[1] = 9'h0AA; exp_h[2] = 9'h101; exp_h[3] = 9'h000;
    send(9'h101); send(9'h0AA); send(9'h155);
    checks++;
    if (last_frame !== 9'h155 || fill_level !== 4'd3 || frame_count !== 16'd3 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_status got lf=%h fill=%0d cnt=%0d ovf=%b want 155 3 3 0",
               last_frame, fill_level, frame_count, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 3'(i);
      @(negedge clk);
      checks++;
      if (hist_frame !== exp_h[i]) begin
        errors++;
        $display("FAIL basic_hist idx=%0d got %h want %h", i, hist_frame, exp_h[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_clear();
    for (int i = 1; i <= 10; i++) send(9'(i));
    checks++;
    if (fill_level !== 4'd8 || overflow !== 1'b1 || frame_count !== 16'd10 || last_frame !== 9'd10) begin
      errors++;
      $display("FAIL wrap_status got fill=%0d ovf=%b cnt=%0d lf=%0d want 8 1 10 10",
               fill_level, overflow, frame_count, last_frame);
    end
    rd_idx = 3'd0;
    @(negedge clk);
    checks++;
    if (hist_frame !== 9'd10) begin
      errors++;
      $display("FAIL wrap_newest got %0d want 10", hist_frame);
    end
    rd_idx = 3'd7;
    @(negedge clk);
    checks++;
    if (hist_frame !== 9'd3) begin
      errors++;
      $display("FAIL wrap_oldest got %0d want 3", hist_frame);
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    send(9'h033); send(9'h044);
    checks++;
    if (last_frame !== 9'd10 || fill_level !== 4'd8 || frame_count !== 16'd10) begin
      errors++;
      $display("FAIL freeze_drop got lf=%h fill=%0d cnt=%0d want 00a 8 10",
               last_frame, fill_level, frame_count);
    end
    freeze = 1'b0;
    send(9'h055);
    checks++;
    if (last_frame !== 9'h055 || frame_count !== 16'd11) begin
      errors++;
      $display("FAIL freeze_release got lf=%h cnt=%0d want 055 11", last_frame, frame_count);
    end
  endtask

  task automatic test_trigger();
    do_clear();
    match_val = 9'h1C3;
    match_en = 1'b1;
    @(negedge clk);
    send(9'h010); send(9'h1C3); send(9'h020); send(9'h030); send(9'h040);
    checks++;
    if (triggered !== 1'b0) begin
      errors++;
      $display("FAIL trig_early got %b want 0", triggered);
    end
    send(9'h050);
    checks++;
    if (triggered !== 1'b1) begin
      errors++;
      $display("FAIL trig_fire got %b want 1", triggered);
    end
    send(9'h060);
    checks++;
    if (last_frame !== 9'h050 || frame_count !== 16'd6 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL trig_frozen got lf=%h cnt=%0d trg=%b want 050 6 1",
               last_frame, frame_count, triggered);
    end
    rd_idx = 3'd4;
    @(negedge clk);
    checks++;
    if (hist_frame !== 9'h1C3) begin
      errors++;
      $display("FAIL trig_hist got %h want 1c3", hist_frame);
    end
  endtask

  task automatic test_clear_priority();
    @(negedge clk);
    clear = 1'b1;
    frame = 9'h0FF;
    frame_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    frame_valid = 1'b0;
    checks++;
    if (frame_count !== 16'd0 || fill_level !== 4'd0 || overflow !== 1'b0 ||
        triggered !== 1'b0 || last_frame !== 9'h000) begin
      errors++;
      $display("FAIL clear_state got cnt=%0d fill=%0d ovf=%b trg=%b lf=%h want 0 0 0 0 000",
               frame_count, fill_level, overflow, triggered, last_frame);
    end
    send(9'h012);
    rd_idx = 3'd0;
    @(negedge clk);
    checks++;
    if (last_frame !== 9'h012 || frame_count !== 16'd1 || fill_level !== 4'd1 || hist_frame !== 9'h012) begin
      errors++;
      $display("FAIL clear_next got lf=%h cnt=%0d fill=%0d hf=%h want 012 1 1 012",
               last_frame, frame_count, fill_level, hist_frame);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    @(negedge clk);
    send(9'h1C3); send(9'h020);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({last_frame, hist_frame, fill_level, frame_count, overflow, triggered} !== 41'd0) begin
      errors++;
      $display("FAIL async_rst got lf=%h hf=%h fill=%0d cnt=%0d ovf=%b trg=%b want all 0",
               last_frame, hist_frame, fill_level, frame_count, overflow, triggered);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(9'h1C3); send(9'h001); send(9'h002); send(9'h003);
    checks++;
    if (triggered !== 1'b0) begin
      errors++;
      $display("FAIL rearm_early got %b want 0", triggered);
    end
    send(9'h004);
    checks++;
    if (triggered !== 1'b1 || frame_count !== 16'd5) begin
      errors++;
      $display("FAIL rearm_fire got trg=%b cnt=%0d want 1 5", triggered, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_freeze();
    test_trigger();
    test_clear_priority();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
